// File: rtl/fp_mul_pipe.sv
//------------------------------------------------------------------------------
// Module      : fp_mul_pipe
// Description : 3-stage pipelined IEEE-754-style multiplier, RNE rounding,
//               valid/ready backpressure. Define FP_MUL_FLAGS_EN for o_flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_mul_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int DATA_W = 1 + EXP_W + FRAC_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data_a,
   input  logic [DATA_W-1:0] i_data_b,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
`ifdef FP_MUL_FLAGS_EN
   ,
   output logic [3:0]        o_flags
`endif
);

   localparam int c_prod_w = 2 * FRAC_W + 2;
   localparam int c_xexp_w = EXP_W + 2;
   localparam logic [c_xexp_w-1:0] c_bias    = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [c_xexp_w-1:0] c_exp_max = {2'b00, {EXP_W{1'b1}}};

   logic w_stall;
   logic w_adv;

   // Stage 1 operand decode
   logic              w_sa, w_sb;
   logic [EXP_W-1:0]  w_ea, w_eb;
   logic [FRAC_W-1:0] w_fa, w_fb;
   logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic              w_nan, w_inf, w_zero;
   logic [c_xexp_w-1:0] w_exp_sum;

   // Stage 3 normalise / round
   logic                w_msb;
   logic [2*FRAC_W:0]   w_norm;
   logic [FRAC_W-1:0]   w_frac;
   logic                w_lsb, w_rnd, w_stk, w_rup, w_carry;
   logic [FRAC_W+1:0]   w_mant_r;
   logic [FRAC_W-1:0]   w_frac_r;
   logic [c_xexp_w-1:0] w_exp_fin;
   logic                w_ovf, w_unf;
   logic [DATA_W-1:0]   w_result;

   // Pipeline registers
   logic                s1_valid_q, s1_valid_d;
   logic                s1_sign_q, s1_sign_d;
   logic [c_xexp_w-1:0] s1_exp_q, s1_exp_d;
   logic [FRAC_W:0]     s1_mant_a_q, s1_mant_a_d;
   logic [FRAC_W:0]     s1_mant_b_q, s1_mant_b_d;
   logic                s1_nan_q, s1_nan_d;
   logic                s1_inf_q, s1_inf_d;
   logic                s1_zero_q, s1_zero_d;

   logic                s2_valid_q, s2_valid_d;
   logic                s2_sign_q, s2_sign_d;
   logic [c_xexp_w-1:0] s2_exp_q, s2_exp_d;
   logic [c_prod_w-1:0] s2_prod_q, s2_prod_d;
   logic                s2_nan_q, s2_nan_d;
   logic                s2_inf_q, s2_inf_d;
   logic                s2_zero_q, s2_zero_d;

   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;

`ifdef FP_MUL_FLAGS_EN
   logic       w_invalid;
   logic [3:0] w_flags;
   logic       s1_invalid_q, s1_invalid_d;
   logic       s2_invalid_q, s2_invalid_d;
   logic [3:0] out_flags_q, out_flags_d;
`endif

   assign w_stall = out_valid_q & ~i_ready;
   assign w_adv   = ~w_stall;
   assign o_ready = w_adv;
   assign o_valid = out_valid_q;
   assign o_data  = out_data_q;
`ifdef FP_MUL_FLAGS_EN
   assign o_flags = out_flags_q;
`endif

   always_comb begin
      w_sa = i_data_a[DATA_W-1];
      w_sb = i_data_b[DATA_W-1];
      w_ea = i_data_a[DATA_W-2 -: EXP_W];
      w_eb = i_data_b[DATA_W-2 -: EXP_W];
      w_fa = i_data_a[FRAC_W-1:0];
      w_fb = i_data_b[FRAC_W-1:0];
      // Zero exponent covers subnormals too: they flush to zero.
      w_za = ~|w_ea;
      w_zb = ~|w_eb;
      w_ia = (&w_ea) & ~|w_fa;
      w_ib = (&w_eb) & ~|w_fb;
      w_na = (&w_ea) & |w_fa;
      w_nb = (&w_eb) & |w_fb;
      w_nan  = w_na | w_nb | (w_ia & w_zb) | (w_ib & w_za);
      w_inf  = ~w_nan & (w_ia | w_ib);
      w_zero = ~w_nan & ~w_inf & (w_za | w_zb);
      w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;
`ifdef FP_MUL_FLAGS_EN
      w_invalid = (w_ia & w_zb) | (w_ib & w_za);
`endif
   end

   always_comb begin
      w_msb    = s2_prod_q[c_prod_w-1];
      w_norm   = w_msb ? s2_prod_q[2*FRAC_W:0] : {s2_prod_q[2*FRAC_W-1:0], 1'b0};
      w_frac   = w_norm[2*FRAC_W:FRAC_W+1];
      w_lsb    = w_norm[FRAC_W+1];
      w_rnd    = w_norm[FRAC_W];
      w_stk    = |w_norm[FRAC_W-1:0];
      w_rup    = w_rnd & (w_stk | w_lsb);
      w_mant_r = {2'b01, w_frac} + {{(FRAC_W+1){1'b0}}, w_rup};
      w_carry  = w_mant_r[FRAC_W+1];
      w_frac_r = w_carry ? w_mant_r[FRAC_W:1] : w_mant_r[FRAC_W-1:0];
      w_exp_fin = s2_exp_q + {{(c_xexp_w-1){1'b0}}, w_msb}
                           + {{(c_xexp_w-1){1'b0}}, w_carry};
      // Exponent is two's complement; the top bit marks a negative value.
      w_ovf = ~w_exp_fin[c_xexp_w-1] & (w_exp_fin >= c_exp_max);
      w_unf = w_exp_fin[c_xexp_w-1] | (w_exp_fin == '0);

`ifdef FP_MUL_FLAGS_EN
      w_flags = 4'b0000;
`endif
      if (s2_nan_q) begin
         w_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         w_flags  = {s2_invalid_q, 3'b000};
`endif
      end else if (s2_inf_q) begin
         w_result = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (s2_zero_q) begin
         w_result = {s2_sign_q, {(EXP_W+FRAC_W){1'b0}}};
      end else if (w_ovf) begin
         w_result = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         w_flags  = 4'b0101;
`endif
      end else if (w_unf) begin
         w_result = {s2_sign_q, {(EXP_W+FRAC_W){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         w_flags  = 4'b0011;
`endif
      end else begin
         w_result = {s2_sign_q, w_exp_fin[EXP_W-1:0], w_frac_r};
`ifdef FP_MUL_FLAGS_EN
         w_flags  = {3'b000, w_rnd | w_stk};
`endif
      end
   end

   // All stages hold together under backpressure; bubbles move like data.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_mant_a_d = s1_mant_a_q;
      s1_mant_b_d = s1_mant_b_q;
      s1_nan_d    = s1_nan_q;
      s1_inf_d    = s1_inf_q;
      s1_zero_d   = s1_zero_q;
      s2_valid_d  = s2_valid_q;
      s2_sign_d   = s2_sign_q;
      s2_exp_d    = s2_exp_q;
      s2_prod_d   = s2_prod_q;
      s2_nan_d    = s2_nan_q;
      s2_inf_d    = s2_inf_q;
      s2_zero_d   = s2_zero_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef FP_MUL_FLAGS_EN
      s1_invalid_d = s1_invalid_q;
      s2_invalid_d = s2_invalid_q;
      out_flags_d  = out_flags_q;
`endif
      if (w_adv) begin
         s1_valid_d  = i_valid;
         s1_sign_d   = w_sa ^ w_sb;
         s1_exp_d    = w_exp_sum;
         s1_mant_a_d = {1'b1, w_fa};
         s1_mant_b_d = {1'b1, w_fb};
         s1_nan_d    = w_nan;
         s1_inf_d    = w_inf;
         s1_zero_d   = w_zero;
         s2_valid_d  = s1_valid_q;
         s2_sign_d   = s1_sign_q;
         s2_exp_d    = s1_exp_q;
         s2_prod_d   = {{(FRAC_W+1){1'b0}}, s1_mant_a_q} * {{(FRAC_W+1){1'b0}}, s1_mant_b_q};
         s2_nan_d    = s1_nan_q;
         s2_inf_d    = s1_inf_q;
         s2_zero_d   = s1_zero_q;
         out_valid_d = s2_valid_q;
         out_data_d  = w_result;
`ifdef FP_MUL_FLAGS_EN
         s1_invalid_d = w_invalid;
         s2_invalid_d = s1_invalid_q;
         out_flags_d  = w_flags;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_mant_a_q <= '0;
         s1_mant_b_q <= '0;
         s1_nan_q    <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_zero_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_exp_q    <= '0;
         s2_prod_q   <= '0;
         s2_nan_q    <= 1'b0;
         s2_inf_q    <= 1'b0;
         s2_zero_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef FP_MUL_FLAGS_EN
         s1_invalid_q <= 1'b0;
         s2_invalid_q <= 1'b0;
         out_flags_q  <= 4'b0000;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_mant_a_q <= s1_mant_a_d;
         s1_mant_b_q <= s1_mant_b_d;
         s1_nan_q    <= s1_nan_d;
         s1_inf_q    <= s1_inf_d;
         s1_zero_q   <= s1_zero_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_exp_q    <= s2_exp_d;
         s2_prod_q   <= s2_prod_d;
         s2_nan_q    <= s2_nan_d;
         s2_inf_q    <= s2_inf_d;
         s2_zero_q   <= s2_zero_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef FP_MUL_FLAGS_EN
         s1_invalid_q <= s1_invalid_d;
         s2_invalid_q <= s2_invalid_d;
         out_flags_q  <= out_flags_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_fp_mul_pipe
// Description : Scoreboard bench for fp_mul_pipe (FP32 configuration).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_a, i_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]  o_flags;
`endif

   fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_data_a (i_a),
      .i_data_b (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_data   (o_data)
`ifdef FP_MUL_FLAGS_EN
      ,
      .o_flags  (o_flags)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flags;
      int          cyc;
      int          stalls;
   } sb_item_t;

   sb_item_t    sb_q[$];
   sb_item_t    item;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          stall_cnt = 0;
   logic        prev_rst = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        cur_stall;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = '0;
   logic [3:0]  ovr_flags = '0;
   logic [35:0] ref_res;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact remainder compared against one half ulp.
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, za, zb, ia, ib, na, nb, inexact;
      int          ea, eb, e, sh;
      logic [47:0] p, rem, half;
      logic [24:0] q;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      if (na || nb || (ia && zb) || (ib && za))
         return {((ia && zb) || (ib && za)), 3'b000, 32'h7FC00000};
      if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
      if (za || zb) return {4'b0000, s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = 25'(p >> sh);
      rem  = p & ((48'd1 << sh) - 48'd1);
      half = 48'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 25'd1;
      if (q[24]) begin
         q = q >> 1;
         e = e + 1;
      end
      inexact = (rem != 0);
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0011, s, 31'd0};
      return {3'b000, inexact, s, e[7:0], q[22:0]};
   endfunction

   // Monitor: evaluates the handshake that the coming rising edge will perform.
   always @(negedge clk) begin
      #2;
      if (prev_rst) begin
         check_val("rst_o_valid", 64'(o_valid), 64'd0);
         check_val("rst_o_data", 64'(o_data), 64'd0);
      end
      if (rst) begin
         sb_q.delete();
         prev_stall = 1'b0;
      end else begin
         cur_stall = o_valid && !i_ready;
         check_val("o_ready", 64'(o_ready), 64'(!cur_stall));
         if (prev_stall) begin
            check_val("hold_data", 64'(o_data), 64'(prev_data));
            check_val("hold_valid", 64'(o_valid), 64'd1);
         end
         if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
               check_val("spurious_out", 64'(o_valid), 64'd0);
            end else begin
               item = sb_q.pop_front();
               check_val("data", 64'(o_data), 64'(item.data));
`ifdef FP_MUL_FLAGS_EN
               check_val("flags", 64'(o_flags), 64'(item.flags));
`endif
               check_val("latency", 64'(cyc - item.cyc), 64'(3 + stall_cnt - item.stalls));
            end
         end
         if (i_valid && o_ready) begin
            ref_res     = ref_mul(i_a, i_b);
            item.data   = ovr_en ? ovr_data  : ref_res[31:0];
            item.flags  = ovr_en ? ovr_flags : ref_res[35:32];
            item.cyc    = cyc;
            item.stalls = stall_cnt;
            sb_q.push_back(item);
         end
         if (cur_stall) stall_cnt++;
         prev_stall = cur_stall;
         prev_data  = o_data;
      end
      prev_rst = rst;
      cyc++;
   end

   // Drive one operand pair until accepted (entered and left on a falling edge).
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int  t;
      logic acc;
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 100) begin
         i_valid = 1'b1;
         i_a     = a;
         i_b     = b;
         #1;
         acc = o_ready;
         @(negedge clk);
         t++;
      end
      if (!acc) check_val("send_timeout", 64'(acc), 64'd1);
      i_valid = 1'b0;
   endtask

   task automatic send_dir(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d, input logic [3:0] f);
      ovr_en    = 1'b1;
      ovr_data  = d;
      ovr_flags = f;
      send(a, b);
      ovr_en    = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: v[30:23] = 8'h00;
         1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
         2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
         3: v[30:23] = 8'(254 - $urandom_range(0, 3));
         4: v[30:23] = 8'(1 + $urandom_range(0, 3));
         5: v[30:23] = 8'(127 + $urandom_range(0, 2));
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   logic [31:0] st_a [6];
   logic [31:0] st_b [6];

   initial begin
      int   sent;
      int   k;
      logic pend;
      logic [31:0] ra, rb;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Directed vectors with fixed expectations
      send_dir(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000); idle(5);
      send_dir(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001); idle(5);
      send_dir(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101); idle(5);
      send_dir(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000); idle(5);
      send_dir(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011); idle(5);
      send_dir(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
      send_dir(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
      send_dir(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0000);
      idle(6);

      // Back-to-back stream with downstream stalled on cycles 3-7
      st_a = '{32'h3FC00000, 32'h40400000, 32'h3F800001, 32'hC0000000, 32'h7F800000, 32'h00000000};
      st_b = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h40800000, 32'hBF800000, 32'h40000000};
      sent = 0;
      k    = 0;
      while (sent < 6 && k < 40) begin
         i_ready = !(k >= 3 && k <= 7);
         i_valid = 1'b1;
         i_a     = st_a[sent];
         i_b     = st_b[sent];
         #1;
         if (o_ready) sent++;
         @(negedge clk);
         k++;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check_val("stream_sent", 64'(sent), 64'd6);
      idle(8);

      // Random traffic with random backpressure
      pend = 1'b0;
      ra = '0;
      rb = '0;
      for (int c = 0; c < 400; c++) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            ra   = rand_op();
            rb   = rand_op();
         end
         i_valid = pend;
         i_a     = ra;
         i_b     = rb;
         #1;
         if (pend && o_ready) pend = 1'b0;
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      idle(8);

      // Reset with three operations in flight and an operand offered alongside
      send(32'h40000000, 32'h40000000);
      send(32'h40400000, 32'h40000000);
      send(32'h40800000, 32'h40000000);
      rst     = 1'b1;
      i_valid = 1'b1;
      i_a     = 32'h41000000;
      i_b     = 32'h41000000;
      @(negedge clk);
      rst     = 1'b0;
      i_valid = 1'b0;
      idle(1);
      send_dir(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
      idle(6);

      k = 0;
      while ((sb_q.size() != 0 || o_valid) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_val("drain", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
